// File: rtl/naive_bus_rom_arbiter_pkg.sv
// Shared types and helpers for the naive-bus arbiters (ROM arbiter today, data-RAM arbiter later).
package naive_arb_pkg;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef logic [0:0] master_id_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/naive_bus_rom_arbiter_if.sv
// One naive-bus port: request/grant handshake, address/data, read data returned one cycle after grant.
interface naive_bus_rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              wr_req;
  logic              rd_gnt;
  logic              wr_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_req, wr_req, rd_addr, wr_addr, wr_data,
    input  rd_gnt, wr_gnt, rd_data
  );

  modport slave (
    input  rd_req, wr_req, rd_addr, wr_addr, wr_data,
    output rd_gnt, wr_gnt, rd_data
  );
endinterface

// File: rtl/naive_bus_rom_arbiter_rr_pick2.sv
// Two-way winner selection: round-robin against last_win, or fixed priority with m0 first.
module rr_pick2
  import naive_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       act0,
  input  logic       act1,
  input  master_id_t last_win,
  output master_id_t winner,
  output logic       any
);

  always_comb begin
    winner = 1'b0;
    any    = act0 | act1;
    if (act0 && act1) begin
      winner = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_win;
    end else if (act1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/naive_bus_rom_arbiter.sv
// Two-master naive-bus arbiter sharing the instruction ROM between fetch (m0) and loader (m1).
// Define ROM_ARB_PERF_CNT_EN to add grant and conflict performance counters.
module naive_bus_rom_arbiter
  import naive_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  naive_bus_rom_arbiter_if.slave  m0,
  naive_bus_rom_arbiter_if.slave  m1,
  naive_bus_rom_arbiter_if.master s
`ifdef ROM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] m0_gnt_cnt,
  output logic [31:0] m1_gnt_cnt,
  output logic [31:0] conflict_cnt
`endif
);

  logic              act0, act1, any;
  logic              rd_granted, any_granted;
  master_id_t        winner, last_win, rd_own;
  logic              rd_own_v;
  logic              sel_rd_req, sel_wr_req;
  logic [ADDR_W-1:0] sel_rd_addr, sel_wr_addr;
  logic [DATA_W-1:0] sel_wr_data;

  assign act0 = m0.rd_req | m0.wr_req;
  assign act1 = m1.rd_req | m1.wr_req;

  rr_pick2 #(.PRIO_MODE(PRIO_MODE)) u_pick (
    .act0     (act0),
    .act1     (act1),
    .last_win (last_win),
    .winner   (winner),
    .any      (any)
  );

  always_comb begin
    sel_rd_req  = 1'b0;
    sel_wr_req  = 1'b0;
    sel_rd_addr = '0;
    sel_wr_addr = '0;
    sel_wr_data = '0;
    if (any) begin
      if (winner == 1'b1) begin
        sel_rd_req  = m1.rd_req;
        sel_wr_req  = m1.wr_req;
        sel_rd_addr = m1.rd_addr;
        sel_wr_addr = m1.wr_addr;
        sel_wr_data = m1.wr_data;
      end else begin
        sel_rd_req  = m0.rd_req;
        sel_wr_req  = m0.wr_req;
        sel_rd_addr = m0.rd_addr;
        sel_wr_addr = m0.wr_addr;
        sel_wr_data = m0.wr_data;
      end
    end
  end

  assign s.rd_req  = sel_rd_req;
  assign s.wr_req  = sel_wr_req;
  assign s.rd_addr = sel_rd_addr;
  assign s.wr_addr = sel_wr_addr;
  assign s.wr_data = sel_wr_data;

  assign m0.rd_gnt = any && (winner == 1'b0) && s.rd_gnt && m0.rd_req;
  assign m0.wr_gnt = any && (winner == 1'b0) && s.wr_gnt && m0.wr_req;
  assign m1.rd_gnt = any && (winner == 1'b1) && s.rd_gnt && m1.rd_req;
  assign m1.wr_gnt = any && (winner == 1'b1) && s.wr_gnt && m1.wr_req;

  assign rd_granted  = m0.rd_gnt | m1.rd_gnt;
  assign any_granted = rd_granted | m0.wr_gnt | m1.wr_gnt;

  // Read data is steered by the registered owner, so a new grant never disturbs the return in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= 1'b1;
      rd_own_v <= 1'b0;
      rd_own   <= 1'b0;
    end else begin
      if (any_granted) last_win <= winner;
      rd_own_v <= rd_granted;
      rd_own   <= winner;
    end
  end

  assign m0.rd_data = (rd_own_v && (rd_own == 1'b0)) ? s.rd_data : '0;
  assign m1.rd_data = (rd_own_v && (rd_own == 1'b1)) ? s.rd_data : '0;

`ifdef ROM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_gnt_cnt   <= '0;
      m1_gnt_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (m0.rd_gnt || m0.wr_gnt) m0_gnt_cnt   <= sat_inc(m0_gnt_cnt);
      if (m1.rd_gnt || m1.wr_gnt) m1_gnt_cnt   <= sat_inc(m1_gnt_cnt);
      if (act0 && act1)           conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule
